// File: rtl/qisp_isa_pkg.sv
// qisp ISA definitions shared by the decode stage.
// Contents: instruction field positions, OP codes, the FRONT register alias,
// the STOP word, and a helper that splits a 16-bit word into its raw fields.
package qisp_isa_pkg;

  localparam int INSTR_W = 16;

  localparam int I_BIT   = 15;
  localparam int OP_MSB  = 14;
  localparam int OP_LSB  = 12;
  localparam int RA_MSB  = 11;
  localparam int RA_LSB  = 8;
  localparam int RB_MSB  = 7;
  localparam int RB_LSB  = 4;
  localparam int RD_MSB  = 3;
  localparam int RD_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MEM = 3'b111;

  localparam logic [3:0]         REG_FRONT = 4'hF;
  localparam logic [INSTR_W-1:0] STOP_WORD = 16'h0000;

  typedef struct packed {
    logic       i;
    logic [2:0] op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rd;
    logic [7:0] imm8;
  } instr_fields_t;

  // rb/rd and imm8 overlap in the encoding; the caller picks based on i.
  function automatic instr_fields_t split_instr(input logic [INSTR_W-1:0] w);
    instr_fields_t f;
    f.i    = w[I_BIT];
    f.op   = w[OP_MSB:OP_LSB];
    f.ra   = w[RA_MSB:RA_LSB];
    f.rb   = w[RB_MSB:RB_LSB];
    f.rd   = w[RD_MSB:RD_LSB];
    f.imm8 = w[IMM_MSB:IMM_LSB];
    return f;
  endfunction

endpackage

// File: rtl/reg_queue_ptr.sv
// Head/tail/occupancy tracking for the register queue window.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clear         empty the queue (pointers and count to 0)
//   push, pop     advance tail / head; both together keep count unchanged
//   head, tail    window-relative pointers, wrap modulo DEPTH
//   count         occupancy 0..DEPTH
//   full, empty   count == DEPTH / count == 0
module reg_queue_ptr #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  output logic [$clog2(DEPTH)-1:0] head,
  output logic [$clog2(DEPTH)-1:0] tail,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/id_stage.sv
// Registered instruction-decode stage for the qisp core (fetch -> decode -> execute).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    drop pending output, empty the register queue
//   in_valid/in_ready/in_instr   fetch handshake and instruction word
//   out_valid/out_ready      execute handshake
//   out_is_stop .. out_imm   registered decoded fields (FRONT already resolved)
//   halted                   sticky once STOP is decoded, cleared only by rst
//   q_count                  register queue occupancy
module id_stage
  import qisp_isa_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int QUEUE_BASE  = 8,
  parameter int QUEUE_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [15:0]                    in_instr,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_is_stop,
  output logic                           out_op_type,
  output logic [2:0]                     out_sel_alu,
  output logic [3:0]                     out_ra,
  output logic                           out_sel_b,
  output logic [3:0]                     out_rb,
  output logic [3:0]                     out_rd,
  output logic [DATA_W-1:0]              out_imm,
  output logic                           halted,
  output logic [$clog2(QUEUE_DEPTH):0]   q_count
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);

  instr_fields_t      f;
  logic               is_stop;
  logic               pop;
  logic               push;
  logic               q_stall;
  logic               accept;
  logic               q_full;
  logic               q_empty;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;

  logic               nxt_op_type;
  logic [3:0]         nxt_rb;
  logic [3:0]         nxt_rd;
  logic [DATA_W-1:0]  nxt_imm;

  reg_queue_ptr #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (accept && push),
    .pop   (accept && pop),
    .head  (head),
    .tail  (tail),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_comb begin
    f       = split_instr(in_instr);
    is_stop = (in_instr == STOP_WORD);
    pop     = !f.i && (f.rb == REG_FRONT);
    push    = f.i || (f.rd == REG_FRONT);
    // A simultaneous pop frees the slot the push needs, so full only stalls a lone push.
    q_stall = (pop && q_empty) || (push && !pop && q_full);
  end

  // Combinational on in_instr by design: a stalling word is refused in the same cycle.
  assign in_ready = !rst && !flush && !halted && (!out_valid || out_ready)
                    && !(in_valid && q_stall);
  assign accept   = in_valid && in_ready;

  always_comb begin
    nxt_op_type = (f.op == OP_MEM);
    nxt_rb      = '0;
    nxt_rd      = f.rd;
    nxt_imm     = '0;
    if (f.i) begin
      nxt_imm = DATA_W'(f.imm8);
    end else begin
      nxt_rb = pop ? 4'(QUEUE_BASE) + 4'(head) : f.rb;
    end
    if (push) nxt_rd = 4'(QUEUE_BASE) + 4'(tail);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_is_stop <= 1'b0;
      out_op_type <= 1'b0;
      out_sel_alu <= '0;
      out_ra      <= '0;
      out_sel_b   <= 1'b0;
      out_rb      <= '0;
      out_rd      <= '0;
      out_imm     <= '0;
      halted      <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      if (is_stop) begin
        out_is_stop <= 1'b1;
        out_op_type <= 1'b0;
        out_sel_alu <= '0;
        out_ra      <= '0;
        out_sel_b   <= 1'b0;
        out_rb      <= '0;
        out_rd      <= '0;
        out_imm     <= '0;
        halted      <= 1'b1;
      end else begin
        out_is_stop <= 1'b0;
        out_op_type <= nxt_op_type;
        out_sel_alu <= f.op;
        out_ra      <= f.ra;
        out_sel_b   <= f.i;
        out_rb      <= nxt_rb;
        out_rd      <= nxt_rd;
        out_imm     <= nxt_imm;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic        out_is_stop;
  logic        out_op_type;
  logic [2:0]  out_sel_alu;
  logic [3:0]  out_ra;
  logic        out_sel_b;
  logic [3:0]  out_rb;
  logic [3:0]  out_rd;
  logic [15:0] out_imm;
  logic        halted;
  logic [3:0]  q_count;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_stage #(
    .DATA_W      (16),
    .QUEUE_BASE  (8),
    .QUEUE_DEPTH (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_is_stop (out_is_stop),
    .out_op_type (out_op_type),
    .out_sel_alu (out_sel_alu),
    .out_ra      (out_ra),
    .out_sel_b   (out_sel_b),
    .out_rb      (out_rb),
    .out_rd      (out_rd),
    .out_imm     (out_imm),
    .halted      (halted),
    .q_count     (q_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 16'h0000; out_ready = 1'b1;

    // 1. reset
    tick; tick;
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_in_ready",  16'(in_ready),  16'h0);
    chk("rst_q_count",   16'(q_count),   16'h0);
    chk("rst_halted",    16'(halted),    16'h0);
    chk("rst_ra",        16'(out_ra),    16'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 16'(in_ready), 16'h1);

    // 2. immediate push
    in_valid = 1'b1; in_instr = 16'h8190;
    #1;
    chk("imm_in_ready", 16'(in_ready), 16'h1);
    tick;
    chk("imm_valid",   16'(out_valid),   16'h1);
    chk("imm_sel_alu", 16'(out_sel_alu), 16'h0);
    chk("imm_ra",      16'(out_ra),      16'h1);
    chk("imm_sel_b",   16'(out_sel_b),   16'h1);
    chk("imm_imm",     out_imm,          16'h0090);
    chk("imm_rd",      16'(out_rd),      16'h8);
    chk("imm_q_count", 16'(q_count),     16'h1);

    // 3. pop, then underflow stall, then flush
    in_instr = 16'h14F3;
    tick;
    chk("pop_sel_alu", 16'(out_sel_alu), 16'h1);
    chk("pop_ra",      16'(out_ra),      16'h4);
    chk("pop_sel_b",   16'(out_sel_b),   16'h0);
    chk("pop_rb",      16'(out_rb),      16'h8);
    chk("pop_rd",      16'(out_rd),      16'h3);
    chk("pop_q_count", 16'(q_count),     16'h0);
    chk("uflow_in_ready", 16'(in_ready), 16'h0);
    tick;
    chk("uflow_out_valid", 16'(out_valid), 16'h0);
    chk("uflow_q_count",   16'(q_count),   16'h0);
    flush = 1'b1;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_release_in_ready", 16'(in_ready), 16'h1);

    // 4. fill to full with tail wrap, overflow stall, push+pop at full
    in_valid = 1'b1; in_instr = 16'h8100;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("fill_rd", 16'(out_rd), 16'(8 + i));
      chk("fill_q_count", 16'(q_count), 16'(i + 1));
    end
    chk("full_in_ready", 16'(in_ready), 16'h0);
    tick;
    chk("full_out_valid", 16'(out_valid), 16'h0);
    chk("full_q_count",   16'(q_count),   16'h8);
    in_instr = 16'h04FF;
    #1;
    chk("pushpop_in_ready", 16'(in_ready), 16'h1);
    tick;
    chk("pushpop_valid",   16'(out_valid), 16'h1);
    chk("pushpop_rb",      16'(out_rb),    16'h8);
    chk("pushpop_rd",      16'(out_rd),    16'h8);
    chk("pushpop_ra",      16'(out_ra),    16'h4);
    chk("pushpop_q_count", 16'(q_count),   16'h8);

    // 5. backpressure
    in_valid = 1'b0; flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("bp_flush_q_count", 16'(q_count), 16'h0);
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 16'h8190;
    tick;
    chk("bp_valid", 16'(out_valid), 16'h1);
    in_instr = 16'h2345;
    #1;
    chk("bp_in_ready", 16'(in_ready), 16'h0);
    tick;
    chk("bp_hold_valid", 16'(out_valid), 16'h1);
    chk("bp_hold_ra",    16'(out_ra),    16'h1);
    chk("bp_hold_imm",   out_imm,        16'h0090);
    chk("bp_hold_rd",    16'(out_rd),    16'h8);
    chk("bp_hold_sel_b", 16'(out_sel_b), 16'h1);
    chk("bp_q_count",    16'(q_count),   16'h1);
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 16'(in_ready), 16'h1);
    tick;
    chk("bp_next_valid",   16'(out_valid),   16'h1);
    chk("bp_next_sel_alu", 16'(out_sel_alu), 16'h2);
    chk("bp_next_ra",      16'(out_ra),      16'h3);
    chk("bp_next_rb",      16'(out_rb),      16'h4);
    chk("bp_next_rd",      16'(out_rd),      16'h5);
    chk("bp_next_sel_b",   16'(out_sel_b),   16'h0);
    chk("bp_next_imm",     out_imm,          16'h0000);

    // memory op with pass-through registers inside the queue window
    in_instr = 16'h7A9C;
    tick;
    chk("mem_op_type", 16'(out_op_type), 16'h1);
    chk("mem_sel_alu", 16'(out_sel_alu), 16'h7);
    chk("mem_ra",      16'(out_ra),      16'hA);
    chk("mem_rb",      16'(out_rb),      16'h9);
    chk("mem_rd",      16'(out_rd),      16'hC);
    chk("mem_q_count", 16'(q_count),     16'h1);

    // 6. STOP, then flush while output is held
    in_instr = 16'h0000;
    tick;
    out_ready = 1'b0;
    in_instr = 16'h8190;
    chk("stop_valid",   16'(out_valid),   16'h1);
    chk("stop_is_stop", 16'(out_is_stop), 16'h1);
    chk("stop_halted",  16'(halted),      16'h1);
    chk("stop_ra",      16'(out_ra),      16'h0);
    chk("stop_op_type", 16'(out_op_type), 16'h0);
    #1;
    chk("stop_in_ready", 16'(in_ready), 16'h0);
    tick;
    chk("stop_hold_valid", 16'(out_valid), 16'h1);
    flush = 1'b1;
    tick;
    flush = 1'b0; out_ready = 1'b1;
    chk("stopflush_valid",   16'(out_valid), 16'h0);
    chk("stopflush_q_count", 16'(q_count),   16'h0);
    chk("stopflush_halted",  16'(halted),    16'h1);
    #1;
    chk("halted_in_ready", 16'(in_ready), 16'h0);
    tick;
    chk("halted_no_accept", 16'(out_valid), 16'h0);

    rst = 1'b1;
    tick;
    chk("rst2_halted", 16'(halted), 16'h0);
    rst = 1'b0;
    #1;
    chk("rst2_in_ready", 16'(in_ready), 16'h1);
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
